// File: rtl/spi_master_byte_if.sv
// Byte-stream and serial-pin bundle for spi_master_byte; the master modport is the
// SPI master's view, the slave modport is the byte producer / pin consumer view.
interface spi_master_byte_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       SCK;
  logic       MOSI;
  logic       SSEL;
  logic       MISO;

  modport master (
    input  tx_valid, tx_data, tx_last, MISO,
    output tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
  );

  modport slave (
    output tx_valid, tx_data, tx_last, MISO,
    input  tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
  );
endinterface

// File: rtl/spi_master_byte.sv
// Mode-0 byte SPI master: turns a valid/ready byte stream into SCK/MOSI/SSEL framing
// and returns the MISO byte captured during each transfer.
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  spi_master_byte_if.master bus
);

  // div spans the doubled deselect count in GAP as well as one SCK half-period
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_MAX  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, HIGH, LOW, WAIT_NEXT, TRAIL, GAP
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    tx_sh_q;
  logic [7:0]    rx_sh_q;
  logic [7:0]    rx_data_q;
  logic          last_q;
  logic          sck_q;
  logic          ssel_q;
  logic          done_q;
  logic          rx_valid_q;
  logic [1:0]    miso_sync_q;

  logic ready;
  logic accept;
  logic half_end;
  logic gap_end;

  assign ready    = ((state_q == IDLE) || (state_q == WAIT_NEXT)) && !RST;
  assign accept   = bus.tx_valid && ready;
  assign half_end = (div_q == HALF_MAX);
  assign gap_end  = (div_q == GAP_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bitcnt_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      last_q      <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      miso_sync_q <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], bus.MISO};
      // rx_valid trails the final SCK fall by one cycle
      done_q      <= 1'b0;
      rx_valid_q  <= done_q;
      if (done_q) rx_data_q <= rx_sh_q;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tx_sh_q  <= bus.tx_data;
            last_q   <= bus.tx_last;
            ssel_q   <= 1'b0;
            bitcnt_q <= '0;
            div_q    <= '0;
            state_q  <= LEAD;
          end
        end
        LEAD, LOW: begin
          if (half_end) begin
            div_q   <= '0;
            sck_q   <= 1'b1;
            state_q <= HIGH;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        HIGH: begin
          if (half_end) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            rx_sh_q <= {rx_sh_q[6:0], miso_sync_q[1]};
            if (bitcnt_q != 3'd7) begin
              bitcnt_q <= bitcnt_q + 3'd1;
              tx_sh_q  <= {tx_sh_q[6:0], 1'b0};
              state_q  <= LOW;
            end else begin
              done_q  <= 1'b1;
              state_q <= last_q ? TRAIL : WAIT_NEXT;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        WAIT_NEXT: begin
          // LOW supplies the setup half-period ahead of the first rise
          if (accept) begin
            tx_sh_q  <= bus.tx_data;
            last_q   <= bus.tx_last;
            bitcnt_q <= '0;
            div_q    <= '0;
            state_q  <= LOW;
          end
        end
        TRAIL: begin
          if (half_end) begin
            div_q   <= '0;
            ssel_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            div_q   <= '0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.SCK      = sck_q;
  assign bus.SSEL     = ssel_q;
  assign bus.MOSI     = tx_sh_q[7];

endmodule

// File: tb/tb_spi_master_byte.sv
// Randomized bench for spi_master_byte: an event monitor and slave model feed a
// timing/data reference computed from accept cycles and CLK_DIV arithmetic.
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_byte_if bif ();
  spi_master_byte_if bif7 ();

  spi_master_byte #(.CLK_DIV(4)) dut  (.CLK(clk), .RST(rst), .bus(bif.master));
  spi_master_byte #(.CLK_DIV(7)) dut7 (.CLK(clk), .RST(rst), .bus(bif7.master));

  logic       tv = 1'b0;
  logic [7:0] td = 8'h00;
  logic       tl = 1'b0;
  logic       use7 = 1'b0;
  logic       loop = 1'b1;
  logic       slv_bit = 1'b0;
  int         D = 4;

  assign bif.tx_valid  = tv && !use7;
  assign bif7.tx_valid = tv && use7;
  assign bif.tx_data   = td;
  assign bif7.tx_data  = td;
  assign bif.tx_last   = tl;
  assign bif7.tx_last  = tl;
  assign bif.MISO      = loop ? bif.MOSI : slv_bit;
  assign bif7.MISO     = bif7.MOSI;

  logic       sck_m, ssel_m, mosi_m, rxv_m, rdy_m, busy_m;
  logic [7:0] rxd_m;
  assign sck_m  = use7 ? bif7.SCK      : bif.SCK;
  assign ssel_m = use7 ? bif7.SSEL     : bif.SSEL;
  assign mosi_m = use7 ? bif7.MOSI     : bif.MOSI;
  assign rxv_m  = use7 ? bif7.rx_valid : bif.rx_valid;
  assign rxd_m  = use7 ? bif7.rx_data  : bif.rx_data;
  assign rdy_m  = use7 ? bif7.tx_ready : bif.tx_ready;
  assign busy_m = use7 ? bif7.busy     : bif.busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Event log of the serial pins, sampled on the falling clock edge
  int         rise_t[$];
  bit         rise_b[$];
  int         fall_t[$];
  int         sr_t[$];
  int         sf_t[$];
  int         rx_t[$];
  logic [7:0] rx_b[$];
  logic       sck_p = 1'b0;
  logic       ssel_p = 1'b1;
  int         nfall = 0;
  logic [7:0] tx_mem [0:15];
  logic [7:0] slv_mem[0:15];
  logic [7:0] sb;

  always @(negedge clk) begin
    if (sck_m && !sck_p) begin rise_t.push_back(cyc); rise_b.push_back(mosi_m); end
    if (!sck_m && sck_p) fall_t.push_back(cyc);
    if (ssel_m && !ssel_p) sr_t.push_back(cyc);
    if (!ssel_m && ssel_p) sf_t.push_back(cyc);
    if (rxv_m) begin rx_t.push_back(cyc); rx_b.push_back(rxd_m); end
    if (ssel_m) nfall = 0;
    else if (!sck_m && sck_p) nfall++;
    sb = slv_mem[(nfall / 8) % 16];
    slv_bit = sb[7 - (nfall % 8)];
    sck_p  = sck_m;
    ssel_p = ssel_m;
  end

  task automatic clear_log();
    rise_t.delete(); rise_b.delete(); fall_t.delete();
    sr_t.delete(); sf_t.delete(); rx_t.delete(); rx_b.delete();
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Sends tx_mem[0..n-1] as one frame; stall = idle cycles spent in WAIT_NEXT before each later byte
  task automatic run_frame(input string nm, input int n, input int stall, input bit rnd_stall);
    int acc[$];
    int to;
    int st;
    int bad;
    int t_idle;
    logic [7:0] b;
    logic [7:0] exp_rx;
    clear_log();
    for (int i = 0; i < n; i++) begin
      tv = 1'b0;
      to = 0;
      while (!rdy_m && to < 3000) begin step(); to++; end
      check_eq({nm, "_ready_wait"}, (to < 3000) ? 1 : 0, 1);
      if (i > 0) begin
        st  = rnd_stall ? $urandom_range(0, stall) : stall;
        bad = 0;
        for (int s = 0; s < st; s++) begin
          step();
          if (ssel_m !== 1'b0 || sck_m !== 1'b0 || rdy_m !== 1'b1) bad++;
        end
        if (st > 0) check_eq($sformatf("%s_stall_hold%0d", nm, i), bad, 0);
      end
      tv = 1'b1;
      td = tx_mem[i];
      tl = (i == n - 1);
      acc.push_back(cyc);
      step();
      tv = 1'b0;
    end
    to = 0;
    while (busy_m && to < 3000) begin step(); to++; end
    t_idle = cyc;
    repeat (3) step();

    check_eq({nm, "_n_rise"}, rise_t.size(), 8 * n);
    check_eq({nm, "_n_fall"}, fall_t.size(), 8 * n);
    check_eq({nm, "_n_rx"}, rx_t.size(), n);
    check_eq({nm, "_n_ssel_fall"}, sf_t.size(), 1);
    check_eq({nm, "_n_ssel_rise"}, sr_t.size(), 1);
    if (sf_t.size() == 1) check_eq({nm, "_ssel_fall_t"}, sf_t[0], acc[0] + 1);
    if (sr_t.size() == 1) check_eq({nm, "_ssel_rise_t"}, sr_t[0], acc[n-1] + 17 * D + 1);
    check_eq({nm, "_idle_t"}, t_idle, acc[n-1] + 19 * D + 1);
    if (rise_t.size() == 8 * n && fall_t.size() == 8 * n) begin
      check_eq({nm, "_byte_period"}, fall_t[7] - acc[0] - 1, 16 * D);
      for (int i = 0; i < n; i++) begin
        b = tx_mem[i];
        for (int k = 0; k < 8; k++) begin
          check_eq($sformatf("%s_rise%0d_%0d", nm, i, k), rise_t[8*i+k], acc[i] + D * (2*k + 1) + 1);
          check_eq($sformatf("%s_fall%0d_%0d", nm, i, k), fall_t[8*i+k], acc[i] + D * (2*k + 2) + 1);
          check_eq($sformatf("%s_mosi%0d_%0d", nm, i, k), int'(rise_b[8*i+k]), int'(b[7-k]));
        end
      end
    end
    if (rx_t.size() == n) begin
      for (int i = 0; i < n; i++) begin
        exp_rx = (loop || use7) ? tx_mem[i] : slv_mem[i];
        check_eq($sformatf("%s_rx_t%0d", nm, i), rx_t[i], acc[i] + 16 * D + 2);
        check_eq($sformatf("%s_rx_data%0d", nm, i), int'(rx_b[i]), int'(exp_rx));
      end
    end
  endtask

  // tx_valid held high with tx_last=1: three frames back to back
  task automatic run_hold(input logic [7:0] b);
    int a0;
    int p;
    int to;
    p = 19 * D + 1;
    clear_log();
    tv = 1'b0; td = b; tl = 1'b1;
    to = 0;
    while (!rdy_m && to < 3000) begin step(); to++; end
    tv = 1'b1;
    a0 = cyc;
    while (cyc < a0 + 3 * p) step();
    tv = 1'b0;
    to = 0;
    while (busy_m && to < 3000) begin step(); to++; end
    repeat (3) step();
    check_eq("hold_n_ssel_fall", sf_t.size(), 3);
    check_eq("hold_n_ssel_rise", sr_t.size(), 3);
    check_eq("hold_n_rx", rx_t.size(), 3);
    check_eq("hold_n_rise", rise_t.size(), 24);
    if (sf_t.size() == 3 && sr_t.size() == 3) begin
      for (int k = 0; k < 3; k++) check_eq($sformatf("hold_start%0d", k), sf_t[k], a0 + k * p + 1);
      for (int k = 0; k < 2; k++) check_eq($sformatf("hold_gap%0d", k), sf_t[k+1] - sr_t[k], 2 * D + 1);
    end
    if (rx_t.size() == 3)
      for (int k = 0; k < 3; k++) check_eq($sformatf("hold_rx%0d", k), int'(rx_b[k]), int'(b));
  endtask

  initial begin
    int n;
    int to;

    // Reset state
    repeat (3) step();
    check_eq("rst_ssel", bif.SSEL, 1);
    check_eq("rst_sck", bif.SCK, 0);
    check_eq("rst_mosi", bif.MOSI, 0);
    check_eq("rst_ready", bif.tx_ready, 0);
    check_eq("rst_rx_valid", bif.rx_valid, 0);
    check_eq("rst_rx_data", bif.rx_data, 0);
    check_eq("rst_busy", bif.busy, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_ready", bif.tx_ready, 1);
    check_eq("post_rst_ssel", bif.SSEL, 1);
    check_eq("post_rst_sck", bif.SCK, 0);
    check_eq("post_rst_rx_data", bif.rx_data, 0);
    check_eq("post_rst_busy", bif.busy, 0);

    // Single byte loopback
    loop = 1'b1;
    tx_mem[0] = 8'hA5;
    run_frame("single", 1, 0, 1'b0);

    // Three-byte frame against the slave model
    loop = 1'b0;
    tx_mem[0] = 8'h01; tx_mem[1] = 8'h02; tx_mem[2] = 8'h03;
    slv_mem[0] = 8'h7E; slv_mem[1] = 8'h00; slv_mem[2] = 8'h00;
    run_frame("three", 3, 0, 1'b0);

    // Stall in WAIT_NEXT
    tx_mem[0] = 8'($urandom); tx_mem[1] = 8'($urandom);
    slv_mem[0] = 8'($urandom); slv_mem[1] = 8'($urandom);
    run_frame("stall", 2, 50, 1'b0);

    // Reset mid-frame, then a clean 0x3C transfer
    loop = 1'b1;
    clear_log();
    td = 8'($urandom); tl = 1'b1; tv = 1'b1;
    step();
    tv = 1'b0;
    to = 0;
    while (rise_t.size() < 3 && to < 1000) begin step(); to++; end
    check_eq("midrst_third_rise", rise_t.size(), 3);
    rst = 1'b1;
    step();
    check_eq("midrst_ssel", bif.SSEL, 1);
    check_eq("midrst_sck", bif.SCK, 0);
    check_eq("midrst_busy", bif.busy, 0);
    rst = 1'b0;
    repeat (20 * D) step();
    check_eq("midrst_no_rx", rx_t.size(), 0);
    tx_mem[0] = 8'h3C;
    run_frame("after_rst", 1, 0, 1'b0);

    // Back-to-back frames with tx_valid held
    run_hold(8'($urandom));

    // Randomized frames, mixed loopback and slave data
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      loop = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        tx_mem[i]  = 8'($urandom);
        slv_mem[i] = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", r), n, 10, 1'b1);
    end

    // CLK_DIV=7 instance, loopback
    use7 = 1'b1;
    D = 7;
    loop = 1'b1;
    repeat (2) step();
    tx_mem[0] = 8'hA5;
    run_frame("div7", 1, 0, 1'b0);
    tx_mem[0] = 8'($urandom); tx_mem[1] = 8'($urandom);
    run_frame("div7_rnd", 2, 5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
